// File: rtl/uart_rx_fifo_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo_ctrl_if
//  Description : Signal bundle between the UART receiver / register block and
//                the receive FIFO controller.
//                master : drives the receiver, FCR/LCR fields and read strobes
//                slave  : the receive FIFO controller
//                Receiver side : rxclk, rxfinished, dout, pe, fe, bi
//                FCR / LCR     : fifoen, fifo64, rxtrig, rxfifoclr, wls, pen, stb
//                Host strobes  : rd (RBR read), lsrrd (LSR read)
//                Outputs       : rdata, dr, oe, peo, feo, bio, fifoerr,
//                                rxtriggered, timeout, count
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_fifo_ctrl_if #(
    parameter int DEPTH = 64
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          rxclk;
    logic          rxfinished;
    logic [7:0]    dout;
    logic          pe;
    logic          fe;
    logic          bi;
    logic          fifoen;
    logic          fifo64;
    logic [1:0]    rxtrig;
    logic          rxfifoclr;
    logic [1:0]    wls;
    logic          pen;
    logic          stb;
    logic          rd;
    logic          lsrrd;

    logic [7:0]    rdata;
    logic          dr;
    logic          oe;
    logic          peo;
    logic          feo;
    logic          bio;
    logic          fifoerr;
    logic          rxtriggered;
    logic          timeout;
    logic [CW-1:0] count;

    modport master (
        output rxclk, rxfinished, dout, pe, fe, bi,
        output fifoen, fifo64, rxtrig, rxfifoclr, wls, pen, stb,
        output rd, lsrrd,
        input  rdata, dr, oe, peo, feo, bio, fifoerr, rxtriggered, timeout, count
    );

    modport slave (
        input  rxclk, rxfinished, dout, pe, fe, bi,
        input  fifoen, fifo64, rxtrig, rxfifoclr, wls, pen, stb,
        input  rd, lsrrd,
        output rdata, dr, oe, peo, feo, bio, fifoerr, rxtriggered, timeout, count
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo_ctrl
//  Description : UART 16750 receive-side controller. Stores received
//                characters {BI,FE,PE,DATA} in a DEPTH-entry FIFO (or a single
//                holding register in 16450 mode), drives RBR data, LSR receive
//                bits and the trigger-level / character-timeout conditions.
//  Ports       : clk  - system clock
//                rst  - synchronous active-high reset
//                bus  - uart_rx_fifo_ctrl_if.slave (receiver, FCR/LCR fields,
//                       read strobes, status outputs)
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo_ctrl #(
    parameter int DEPTH = 64
) (
    input  wire logic            clk,
    input  wire logic            rst,
    uart_rx_fifo_ctrl_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Storage and registered state
    logic [10:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] err_cnt_q, err_cnt_d;
    logic [9:0]    tcnt_q, tcnt_d;
    logic          oe_q, oe_d;
    logic          peo_q, peo_d;
    logic          feo_q, feo_d;
    logic          bio_q, bio_d;
    logic          fifoen_sh_q;

    // Decoded events
    logic          w_flush;
    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic          w_ovf;
    logic          w_overwrite;
    logic          w_new_head;
    logic [10:0]   w_new;
    logic          w_new_err;
    logic [10:0]   w_head;
    logic          w_head_err;
    logic [AW-1:0] w_rd_next;
    logic [10:0]   w_next_head;
    logic [2:0]    w_flags_set;
    logic [3:0]    w_charbits;
    logic [9:0]    w_thresh;
    logic [CW-1:0] w_level;

    assign w_new      = {bus.bi, bus.fe, bus.pe, bus.dout};
    assign w_new_err  = |w_new[10:8];
    assign w_head     = mem_q[rd_ptr_q];
    assign w_head_err = |w_head[10:8];
    assign w_rd_next  = rd_ptr_q + 1'b1;
    assign w_next_head = mem_q[w_rd_next];

    // Any change of FIFOEN against its shadow copy flushes like RXFIFOCLR.
    assign w_flush = bus.rxfifoclr | (bus.fifoen != fifoen_sh_q);
    assign w_empty = (count_q == '0);
    // Capacity is DEPTH in FIFO mode and a single entry in 16450 mode.
    assign w_full  = bus.fifoen ? (count_q == CW'(DEPTH)) : !w_empty;

    assign w_pop       = bus.rd & !w_empty & !w_flush;
    // A read in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push      = bus.rxfinished & (!w_full | bus.rd) & !w_flush;
    assign w_ovf       = bus.rxfinished & w_full & !bus.rd & !w_flush;
    assign w_overwrite = w_ovf & !bus.fifoen;

    // The incoming character becomes head when it lands in an empty FIFO,
    // when the only stored entry is popped in the same cycle, or when it
    // replaces the 16450 holding register.
    assign w_new_head = (w_push & (w_empty | (w_pop & (count_q == CW'(1))))) | w_overwrite;

    always_comb begin
        w_flags_set = 3'b000;
        if (w_new_head) begin
            w_flags_set = w_new[10:8];
        end else if (w_pop && (count_q > CW'(1))) begin
            w_flags_set = w_next_head[10:8];
        end
    end

    // Four character times of 16 ticks each: 64 x charbits.
    assign w_charbits = 4'd7 + {2'b00, bus.wls} + {3'b000, bus.pen} + {3'b000, bus.stb};
    assign w_thresh   = {w_charbits, 6'b000000};

    always_comb begin
        w_level = CW'(1);
        case ({bus.fifo64, bus.rxtrig})
            3'b000:  w_level = CW'(1);
            3'b001:  w_level = CW'(4);
            3'b010:  w_level = CW'(8);
            3'b011:  w_level = CW'(14);
            3'b100:  w_level = CW'(1);
            3'b101:  w_level = CW'(16);
            3'b110:  w_level = CW'(32);
            default: w_level = CW'(56);
        endcase
    end

    // Next-state computation
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        err_cnt_d = err_cnt_q;
        tcnt_d    = tcnt_q;
        oe_d      = w_ovf       | (oe_q  & !bus.lsrrd);
        peo_d     = w_flags_set[0] | (peo_q & !bus.lsrrd);
        feo_d     = w_flags_set[1] | (feo_q & !bus.lsrrd);
        bio_d     = w_flags_set[2] | (bio_q & !bus.lsrrd);

        if (w_flush) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            err_cnt_d = '0;
            tcnt_d    = '0;
        end else begin
            wr_ptr_d  = wr_ptr_q + AW'(w_push);
            rd_ptr_d  = rd_ptr_q + AW'(w_pop);
            count_d   = count_q + CW'(w_push) - CW'(w_pop);
            err_cnt_d = err_cnt_q
                      + CW'(w_push & w_new_err) - CW'(w_pop & w_head_err)
                      + CW'(w_overwrite & w_new_err) - CW'(w_overwrite & w_head_err);
            if (w_push || w_pop || w_empty || !bus.fifoen) begin
                tcnt_d = '0;
            end else if (bus.rxclk && (tcnt_q < w_thresh)) begin
                tcnt_d = tcnt_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            err_cnt_q   <= '0;
            tcnt_q      <= '0;
            oe_q        <= 1'b0;
            peo_q       <= 1'b0;
            feo_q       <= 1'b0;
            bio_q       <= 1'b0;
            fifoen_sh_q <= bus.fifoen;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            err_cnt_q   <= err_cnt_d;
            tcnt_q      <= tcnt_d;
            oe_q        <= oe_d;
            peo_q       <= peo_d;
            feo_q       <= feo_d;
            bio_q       <= bio_d;
            fifoen_sh_q <= bus.fifoen;
        end
    end

    // Storage array is not reset; validity is tracked by the pointers/count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_push) begin
                mem_q[wr_ptr_q] <= w_new;
            end else if (w_overwrite) begin
                mem_q[rd_ptr_q] <= w_new;
            end
        end
    end

    assign bus.rdata       = w_empty ? 8'h00 : w_head[7:0];
    assign bus.dr          = !w_empty;
    assign bus.oe          = oe_q;
    assign bus.peo         = peo_q;
    assign bus.feo         = feo_q;
    assign bus.bio         = bio_q;
    assign bus.fifoerr     = bus.fifoen & (err_cnt_q != '0);
    assign bus.rxtriggered = bus.fifoen & (count_q >= w_level);
    assign bus.timeout     = bus.fifoen & !w_empty & (tcnt_q >= w_thresh);
    assign bus.count       = count_q;
endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_fifo_ctrl
//  Description : Directed testbench for uart_rx_fifo_ctrl with hand-computed
//                expected values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo_ctrl;
    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    uart_rx_fifo_ctrl_if #(.DEPTH(64)) bus ();

    uart_rx_fifo_ctrl #(.DEPTH(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic p, input logic f, input logic b);
        bus.rxfinished = 1'b1;
        bus.dout = d;
        bus.pe = p;
        bus.fe = f;
        bus.bi = b;
        tick();
        bus.rxfinished = 1'b0;
        bus.pe = 1'b0;
        bus.fe = 1'b0;
        bus.bi = 1'b0;
    endtask

    task automatic rd_pulse();
        bus.rd = 1'b1;
        tick();
        bus.rd = 1'b0;
    endtask

    task automatic lsr_read();
        bus.lsrrd = 1'b1;
        tick();
        bus.lsrrd = 1'b0;
    endtask

    task automatic rx_ticks(input int n);
        for (int k = 0; k < n; k++) begin
            bus.rxclk = 1'b1;
            tick();
            bus.rxclk = 1'b0;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        bus.rxclk = 0; bus.rxfinished = 0; bus.dout = 0;
        bus.pe = 0; bus.fe = 0; bus.bi = 0;
        bus.fifoen = 1; bus.fifo64 = 1; bus.rxtrig = 2'b01; bus.rxfifoclr = 0;
        bus.wls = 2'b00; bus.pen = 0; bus.stb = 0; bus.rd = 0; bus.lsrrd = 0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_count", bus.count, 0);
        chk("rst_dr", bus.dr, 0);
        chk("rst_rdata", bus.rdata, 0);
        chk("rst_oe", bus.oe, 0);
        chk("rst_errbits", {bus.peo, bus.feo, bus.bio}, 0);
        chk("rst_fifoerr", bus.fifoerr, 0);
        chk("rst_trig", bus.rxtriggered, 0);
        chk("rst_timeout", bus.timeout, 0);

        // Trigger level 16 (FIFO64=1, RXTRIG=01)
        for (int i = 0; i < 16; i++) begin
            push(8'(i), 0, 0, 0);
            if (i == 14) chk("trig_15", bus.rxtriggered, 0);
        end
        chk("trig_16", bus.rxtriggered, 1);
        chk("trig_count", bus.count, 16);
        for (int i = 0; i < 16; i++) begin
            chk("trig_rdata", bus.rdata, i);
            rd_pulse();
        end
        chk("trig_dr_end", bus.dr, 0);

        // Overflow at full: character discarded, OE set
        for (int i = 0; i < 64; i++) push(8'(i), 0, 0, 0);
        chk("full_count", bus.count, 64);
        push(8'hAA, 0, 0, 0);
        chk("ovf_oe", bus.oe, 1);
        chk("ovf_count", bus.count, 64);
        for (int i = 0; i < 64; i++) begin
            chk("ovf_rdata", bus.rdata, i);
            rd_pulse();
        end
        chk("ovf_empty", bus.dr, 0);
        lsr_read();
        chk("ovf_oe_clr", bus.oe, 0);

        // Push at full with simultaneous read: accepted
        for (int i = 0; i < 64; i++) push(8'(i), 0, 0, 0);
        bus.rd = 1'b1;
        push(8'hAA, 0, 0, 0);
        bus.rd = 1'b0;
        chk("rdpush_oe", bus.oe, 0);
        chk("rdpush_count", bus.count, 64);
        for (int i = 1; i < 64; i++) begin
            chk("rdpush_rdata", bus.rdata, i);
            rd_pulse();
        end
        chk("rdpush_last", bus.rdata, 8'hAA);
        rd_pulse();
        chk("rdpush_empty", bus.count, 0);

        // 16450 holding-register mode
        bus.fifoen = 0;
        tick();
        push(8'h11, 0, 0, 0);
        chk("h_rdata1", bus.rdata, 8'h11);
        chk("h_oe0", bus.oe, 0);
        push(8'h22, 0, 0, 0);
        chk("h_oe1", bus.oe, 1);
        chk("h_rdata2", bus.rdata, 8'h22);
        chk("h_count", bus.count, 1);
        chk("h_trig", bus.rxtriggered, 0);
        lsr_read();
        chk("h_oe_clr", bus.oe, 0);
        rd_pulse();
        chk("h_dr", bus.dr, 0);
        bus.fifoen = 1;
        tick();

        // Parity error pushed into empty FIFO is head immediately
        push(8'h5A, 1, 0, 0);
        chk("pe_peo", bus.peo, 1);
        chk("pe_fifoerr", bus.fifoerr, 1);
        lsr_read();
        chk("pe_peo_clr", bus.peo, 0);
        chk("pe_fifoerr_kept", bus.fifoerr, 1);
        rd_pulse();
        chk("pe_fifoerr_clr", bus.fifoerr, 0);

        // BI/FE behind two clean characters
        push(8'hA1, 0, 0, 0);
        push(8'hA2, 0, 0, 0);
        push(8'h00, 0, 1, 1);
        chk("bi_fifoerr", bus.fifoerr, 1);
        chk("bi_not_head", {bus.bio, bus.feo}, 0);
        rd_pulse();
        chk("bi_after_pop1", {bus.bio, bus.feo}, 0);
        rd_pulse();
        chk("bi_head_flags", {bus.bio, bus.feo, bus.peo}, 3'b110);
        chk("bi_head_rdata", bus.rdata, 8'h00);
        lsr_read();
        chk("bi_flags_clr", {bus.bio, bus.feo}, 0);
        chk("bi_fifoerr_kept", bus.fifoerr, 1);
        rd_pulse();
        chk("bi_fifoerr_clr", bus.fifoerr, 0);
        chk("bi_dr", bus.dr, 0);

        // Character timeout, charbits = 11 -> 704 ticks
        bus.fifo64 = 0; bus.wls = 2'b11; bus.pen = 1; bus.stb = 0;
        push(8'h55, 0, 0, 0);
        rx_ticks(703);
        chk("to_703", bus.timeout, 0);
        rx_ticks(1);
        chk("to_704", bus.timeout, 1);
        rx_ticks(5);
        chk("to_sat", bus.timeout, 1);
        push(8'h66, 0, 0, 0);
        chk("to_push_clr", bus.timeout, 0);
        rx_ticks(700);
        rd_pulse();
        chk("to_rd_rdata", bus.rdata, 8'h66);
        rx_ticks(703);
        chk("to_restart_703", bus.timeout, 0);
        rx_ticks(1);
        chk("to_restart_704", bus.timeout, 1);
        rd_pulse();
        chk("to_pop_clr", bus.timeout, 0);

        // Flush behaviour; OE preserved across flushes
        bus.fifoen = 0;
        tick();
        push(8'h31, 0, 0, 0);
        push(8'h32, 0, 0, 0);
        chk("fl_oe_set", bus.oe, 1);
        bus.fifoen = 1;
        tick();
        chk("fl_toggle_count", bus.count, 0);
        chk("fl_toggle_oe", bus.oe, 1);
        push(8'hC1, 0, 0, 0);
        push(8'hC2, 0, 0, 0);
        push(8'hC3, 0, 0, 0);
        chk("fl_count3", bus.count, 3);
        bus.rxfifoclr = 1'b1;
        push(8'h77, 0, 0, 0);
        bus.rxfifoclr = 1'b0;
        chk("fl_count", bus.count, 0);
        chk("fl_dr", bus.dr, 0);
        chk("fl_timeout", bus.timeout, 0);
        chk("fl_oe", bus.oe, 1);
        push(8'h88, 0, 0, 0);
        chk("fl_next_rdata", bus.rdata, 8'h88);
        push(8'h89, 0, 0, 0);
        chk("fl_count2", bus.count, 2);
        bus.fifoen = 0;
        tick();
        chk("fl_toggle2_count", bus.count, 0);
        chk("fl_toggle2_dr", bus.dr, 0);
        bus.fifoen = 1;
        tick();
        lsr_read();
        chk("fl_oe_clr", bus.oe, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
